vdp_bus_if: RTL and testbench
=============================

Name: vdp_bus_if

Overview:
- CPU-side initiator for the VDP VRAM port.
- Converts asynchronous Z8S180 I/O cycles into the single-clock rd_tick/wr_tick/mode/din strobes the vram block consumes.
- Returns read data to the CPU and stretches each cycle with WAIT until the VRAM access has completed.
- Sits between the Z8S180 bus pins and the vdp99 core, in the pixel-clock domain.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the synchronizer on each async bus input (2..3).
- WAIT_CYCLES, 2, clk cycles to hold wait_n low after the tick before releasing the bus (1..7).

Ports:
- clk  in  1  pixel clock (25 MHz).
- reset  in  1  synchronous, active-high.
- ce_n  in  1  decoded VDP chip select from CPU, async.
- iorq_n  in  1  CPU I/O request, async.
- rd_n  in  1  CPU read strobe, async.
- wr_n  in  1  CPU write strobe, async.
- a0  in  1  CPU address bit 0; 1 = control/address port, 0 = data port.
- bus_din  in  8  CPU write data.
- bus_dout  out  8  read data returned to CPU.
- bus_doe  out  1  CPU data-bus output enable.
- wait_n  out  1  CPU WAIT, active-low.
- vdp_wr_tick  out  1  one-clk write strobe to vram.
- vdp_rd_tick  out  1  one-clk read strobe to vram.
- vdp_mode  out  1  mode to vram; equals latched a0.
- vdp_din  out  8  write data to vram.
- vdp_dout  in  8  vram read-ahead data, valid while no tick is in flight.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high.
- Reset values: vdp_wr_tick=0, vdp_rd_tick=0, vdp_mode=0, vdp_din=0, bus_dout=0, bus_doe=0, wait_n=1, FSM=IDLE.
- Synchronization:
  - act_rd = !ce_n & !iorq_n & !rd_n and act_wr = !ce_n & !iorq_n & !wr_n are each passed through SYNC_STAGES flops, giving s_rd and s_wr.
  - a0 and bus_din are captured from flops clocked alongside the final sync stage, so they are stable by the time s_rd or s_wr is seen.
- wait_n:
  - Combinationally 0 whenever !ce_n & !iorq_n & (!rd_n | !wr_n) and the FSM has not reached RELEASE.
  - Otherwise 1.
  - This is the only combinational bus path.
- IDLE:
  - On the cycle s_wr rises while s_rd=0: latch vdp_mode=a0 and vdp_din=bus_din, assert vdp_wr_tick=1 for exactly one clk, go to ACCESS.
  - On the cycle s_rd rises while s_wr=0: latch vdp_mode=a0, capture bus_dout=vdp_dout on that same edge (the read-ahead byte, taken before the advance), assert vdp_rd_tick=1 for exactly one clk, go to ACCESS.
  - If s_rd and s_wr are both high: illegal; no tick is issued, go directly to RELEASE.
- ACCESS:
  - Count WAIT_CYCLES clks with ticks low, then go to RELEASE.
  - Tick-to-RELEASE latency is WAIT_CYCLES+1 clks.
- RELEASE:
  - wait_n is released.
  - Remain until s_rd=0 and s_wr=0, then return to IDLE.
  - No new tick is issued while in RELEASE.
- bus_doe = 1 iff in ACCESS or RELEASE of a read cycle and the raw strobe is still active (!ce_n & !iorq_n & !rd_n). bus_dout holds its value until the next read capture.
- Spacing: exactly one tick per CPU cycle, and consecutive ticks are at least WAIT_CYCLES+2 clks apart, which satisfies vram tick spacing.
- Strobe present during reset: the edge-detect registers reset to "active", so a strobe already asserted when reset deasserts produces no tick and is not seen as a new edge.
- Reset mid-cycle: abort to IDLE on the next clk with wait_n=1, no tick, and no partial write.
- Glitch-free vdp_mode/vdp_din: both change only on the clk that asserts a tick.

Test Plan:
- Reset, then CPU OUT to a0=1 with 0x00, then a0=1 with 0x42 -> two vdp_wr_tick pulses, each 1 clk wide, with vdp_mode=1 and vdp_din=0x00, then 0x42; wait_n low for SYNC_STAGES+WAIT_CYCLES+1 clks per cycle.
- 16 OUTs to a0=0 with data 0x00..0x0F -> 16 wr_ticks, mode=0, vdp_din matching each byte in order, no extra or missing ticks.
- vdp_dout stub returns 0x5A, then 0xA5 after each rd_tick; two INs from a0=0 -> CPU reads 0x5A then 0xA5; exactly one vdp_rd_tick per IN; bus_doe is high only while rd_n is low.
- rd_n and wr_n both low together -> no tick, wait_n released, bus_doe=0.
- wr_n held low across reset deassertion -> no tick until wr_n goes high and low again, which then yields exactly one tick.
- Assert reset during ACCESS of a write -> ticks stay 0 and wait_n=1 on the next clk; the FSM returns to IDLE and the following OUT works normally.

Source files
------------

// File: rtl/vdp_bus_if.sv
// vdp_bus_if: Z8S180 I/O cycle to VDP VRAM tick bridge (pixel-clock domain).
// Synchronizes the asynchronous CPU strobes and turns each CPU cycle into
// exactly one rd/wr tick. WAIT is held low until the VRAM access has settled.
module vdp_bus_if #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_doe,
    output logic       wait_n,
    output logic       vdp_wr_tick,
    output logic       vdp_rd_tick,
    output logic       vdp_mode,
    output logic [7:0] vdp_din,
    input  logic [7:0] vdp_dout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0]      r_rd_sync;
    logic [SYNC_STAGES-1:0]      r_wr_sync;
    logic [SYNC_STAGES-1:0]      r_a0_sync;
    logic [SYNC_STAGES-1:0][7:0] r_din_sync;
    logic                        r_rd_prev;
    logic                        r_wr_prev;
    logic [2:0]                  r_cnt;
    logic                        r_doe_arm;
    logic                        r_blk;
    logic [7:0]                  r_dout;
    logic                        r_wr_tick;
    logic                        r_rd_tick;
    logic                        r_mode;
    logic [7:0]                  r_din;

    logic w_act_rd;
    logic w_act_wr;
    logic w_s_rd;
    logic w_s_wr;
    logic w_rd_rise;
    logic w_wr_rise;
    logic w_do_wr;
    logic w_do_rd;
    logic w_illegal;

    assign w_act_rd  = !ce_n && !iorq_n && !rd_n;
    assign w_act_wr  = !ce_n && !iorq_n && !wr_n;
    assign w_s_rd    = r_rd_sync[SYNC_STAGES-1];
    assign w_s_wr    = r_wr_sync[SYNC_STAGES-1];
    assign w_rd_rise = w_s_rd && !r_rd_prev;
    assign w_wr_rise = w_s_wr && !r_wr_prev;

    // Strobe synchronizers; a0/data ride a parallel pipe of equal depth so
    // they are aligned with (and older than) the strobe that selects them.
    // Chains and edge history reset to "active" so a strobe that is already
    // asserted across reset never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sync  <= '1;
            r_wr_sync  <= '1;
            r_a0_sync  <= '0;
            r_din_sync <= '0;
            r_rd_prev  <= 1'b1;
            r_wr_prev  <= 1'b1;
        end else begin
            r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], w_act_rd};
            r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], w_act_wr};
            r_a0_sync  <= {r_a0_sync[SYNC_STAGES-2:0], a0};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], bus_din};
            r_rd_prev  <= w_s_rd;
            r_wr_prev  <= w_s_wr;
        end
    end

    // FSM state register and ACCESS dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_ACCESS) r_cnt <= r_cnt + 3'd1;
            else                      r_cnt <= '0;
        end
    end

    // Next state and tick requests; simultaneous rd+wr is rejected without a tick.
    always_comb begin
        w_state_nxt = r_state;
        w_do_wr     = 1'b0;
        w_do_rd     = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s_rd && w_s_wr) begin
                    w_illegal   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else if (w_wr_rise) begin
                    w_do_wr     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else if (w_rd_rise) begin
                    w_do_rd     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == 3'(WAIT_CYCLES)) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_s_rd && !w_s_wr) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered VRAM strobes; mode/data only move on the clk that ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_tick <= 1'b0;
            r_rd_tick <= 1'b0;
            r_mode    <= 1'b0;
            r_din     <= '0;
            r_dout    <= '0;
        end else begin
            r_wr_tick <= w_do_wr;
            r_rd_tick <= w_do_rd;
            if (w_do_wr) begin
                r_mode <= r_a0_sync[SYNC_STAGES-1];
                r_din  <= r_din_sync[SYNC_STAGES-1];
            end
            if (w_do_rd) begin
                r_mode <= r_a0_sync[SYNC_STAGES-1];
                r_dout <= vdp_dout;  // read-ahead byte, before vram advances
            end
        end
    end

    // Read-cycle ownership for the data-bus driver, and the post-reset WAIT
    // block: after reset, WAIT stays released until the bus has gone idle so
    // a cycle cut short by reset cannot be left stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_doe_arm <= 1'b0;
            r_blk     <= 1'b1;
        end else begin
            if (w_do_rd)                                     r_doe_arm <= 1'b1;
            else if (w_do_wr || w_illegal || w_state_nxt == ST_IDLE) r_doe_arm <= 1'b0;
            if (!w_s_rd && !w_s_wr) r_blk <= 1'b0;
        end
    end

    assign wait_n      = !((w_act_rd || w_act_wr) && (r_state != ST_RELEASE) && !r_blk);
    assign bus_doe     = r_doe_arm && w_act_rd;
    assign bus_dout    = r_dout;
    assign vdp_wr_tick = r_wr_tick;
    assign vdp_rd_tick = r_rd_tick;
    assign vdp_mode    = r_mode;
    assign vdp_din     = r_din;

endmodule

// File: tb/tb_vdp_bus_if.sv
// Randomized bench for vdp_bus_if: CPU I/O cycles vs a transaction-level model
// (one tick per legal cycle, nth IN returns nth stub byte).
module tb_vdp_bus_if;
    localparam int S = 2;
    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset, ce_n, iorq_n, rd_n, wr_n, a0;
    logic [7:0] bus_din, bus_dout, vdp_din, vdp_dout;
    logic       bus_doe, wait_n, vdp_wr_tick, vdp_rd_tick, vdp_mode;

    int total = 0;
    int bad   = 0;

    logic [7:0] stub_vals [0:63];
    int         rd_ticks = 0;
    logic [8:0] wr_log [$];
    int         exp_rd_idx = 0;

    always #20 clk = ~clk;

    vdp_bus_if #(.SYNC_STAGES(S), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .ce_n(ce_n), .iorq_n(iorq_n), .rd_n(rd_n),
        .wr_n(wr_n), .a0(a0), .bus_din(bus_din), .bus_dout(bus_dout),
        .bus_doe(bus_doe), .wait_n(wait_n), .vdp_wr_tick(vdp_wr_tick),
        .vdp_rd_tick(vdp_rd_tick), .vdp_mode(vdp_mode), .vdp_din(vdp_din),
        .vdp_dout(vdp_dout)
    );

    // VRAM stub: read-ahead byte advances after every rd tick.
    assign vdp_dout = stub_vals[rd_ticks[5:0]];

    always @(negedge clk) begin
        if (vdp_wr_tick === 1'b1) wr_log.push_back({vdp_mode, vdp_din});
        if (vdp_rd_tick === 1'b1) rd_ticks++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        ce_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    // One CPU IN/OUT cycle, checked against the transaction model.
    task automatic cpu_io(input bit is_rd, input bit adr, input logic [7:0] d, input int gap);
        int nlow;
        int wb;
        int rb;
        wb = wr_log.size();
        rb = rd_ticks;
        nlow = 0;
        @(negedge clk);
        a0 = adr; bus_din = d; ce_n = 1'b0; iorq_n = 1'b0;
        if (is_rd) rd_n = 1'b0; else wr_n = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wait_n !== 1'b0) break;
            nlow++;
        end
        chk("wait_len", nlow, S + W + 1);
        chk("mode", vdp_mode, adr);
        if (is_rd) begin
            chk("doe_on", bus_doe, 1'b1);
            chk("rd_data", bus_dout, stub_vals[exp_rd_idx]);
            exp_rd_idx++;
        end else begin
            chk("doe_wr", bus_doe, 1'b0);
        end
        bus_idle();
        #1;
        chk("doe_off", bus_doe, 1'b0);
        repeat (gap) @(negedge clk);
        #1;
        chk("wr_cnt", wr_log.size() - wb, is_rd ? 0 : 1);
        chk("rd_cnt", rd_ticks - rb, is_rd ? 1 : 0);
        if (!is_rd && wr_log.size() > wb) chk("wr_val", wr_log[wr_log.size()-1], {adr, d});
    endtask

    initial begin
        int wb;
        int rb;
        bit seen;
        stub_vals[0] = 8'h5A;
        stub_vals[1] = 8'hA5;
        for (int i = 2; i < 64; i++) stub_vals[i] = 8'($urandom);
        bus_idle();
        a0 = 1'b0; bus_din = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_tick", vdp_wr_tick, 1'b0);
        chk("rst_rd_tick", vdp_rd_tick, 1'b0);
        chk("rst_mode", vdp_mode, 1'b0);
        chk("rst_din", vdp_din, 8'h00);
        chk("rst_dout", bus_dout, 8'h00);
        chk("rst_doe", bus_doe, 1'b0);
        chk("rst_wait", wait_n, 1'b1);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // control-port writes, then 16 data-port writes
        cpu_io(0, 1, 8'h00, 5);
        cpu_io(0, 1, 8'h42, 5);
        for (int i = 0; i < 16; i++) cpu_io(0, 0, 8'(i), 4);

        // two reads of the read-ahead stub
        cpu_io(1, 0, 8'h00, 5);
        cpu_io(1, 0, 8'h00, 5);

        // rd and wr together: no tick, bus released, no drive
        wb = wr_log.size(); rb = rd_ticks;
        @(negedge clk);
        ce_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wait_n === 1'b1) break;
        end
        chk("ill_wait", wait_n, 1'b1);
        chk("ill_doe", bus_doe, 1'b0);
        bus_idle();
        repeat (6) @(negedge clk);
        chk("ill_wr_cnt", wr_log.size() - wb, 0);
        chk("ill_rd_cnt", rd_ticks - rb, 0);

        // write strobe held across reset deassertion
        wb = wr_log.size();
        @(negedge clk);
        reset = 1'b1;
        a0 = 1'b0; bus_din = 8'h77; ce_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_notick", wr_log.size() - wb, 0);
        chk("held_wait", wait_n, 1'b1);
        bus_idle();
        repeat (5) @(negedge clk);
        cpu_io(0, 1, 8'h99, 5);

        // reset during ACCESS of a write
        wb = wr_log.size();
        seen = 1'b0;
        @(negedge clk);
        a0 = 1'b1; bus_din = 8'h3C; ce_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (wr_log.size() > wb) begin seen = 1'b1; break; end
        end
        chk("mid_tick_seen", seen, 1'b1);
        if (seen) chk("mid_tick_val", wr_log[wr_log.size()-1], {1'b1, 8'h3C});
        reset = 1'b1;
        @(negedge clk);
        chk("mid_wr_tick", vdp_wr_tick, 1'b0);
        chk("mid_rd_tick", vdp_rd_tick, 1'b0);
        chk("mid_wait", wait_n, 1'b1);
        chk("mid_mode", vdp_mode, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("mid_no_more", wr_log.size() - wb, 1);
        chk("mid_wait2", wait_n, 1'b1);
        bus_idle();
        repeat (5) @(negedge clk);
        cpu_io(0, 0, 8'h21, 5);

        // randomized mix
        for (int i = 0; i < 40; i++)
            cpu_io(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   $urandom_range(4, 7));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
